// File: rtl/led_pattern_gen_if.sv
// Pin bundle for led_pattern_gen: raw button in, LED pattern / mode / step strobe out.
// No valid/ready pairs here: step_o is a single-cycle strobe marking the cycle led_o changes, button_i is a raw level.
interface led_pattern_gen_if #(
   parameter int N_LEDS = 8
) ();
   logic              button_i;
   logic [N_LEDS-1:0] led_o;
   logic [1:0]        mode_o;
   logic              step_o;

   modport slave  (input  button_i, output led_o, mode_o, step_o);
   modport master (output button_i, input  led_o, mode_o, step_o);
endinterface

// File: rtl/led_pattern_gen.sv
// Board bring-up LED animator: four patterns stepped by a programmable timer,
// mode cycled by a synchronised and debounced push-button.
module led_pattern_gen #(
   parameter int N_LEDS          = 8,
   parameter int STEP_CYCLES     = 5000000,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   led_pattern_gen_if.slave   bus
);

   localparam int TW = $clog2(STEP_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0]     T_LAST  = TW'(STEP_CYCLES - 1);
   localparam logic [DW-1:0]     D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [N_LEDS-1:0] PAT_ONE = N_LEDS'(1);

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_t;

   logic              sync1_q, sync2_q;
   logic              db_level_q;
   logic [DW-1:0]     db_cnt_q;
   logic              press_q;
   logic [TW-1:0]     timer_q;
   logic              tick;
   logic              step_q;
   mode_t             mode_q, mode_d;
   logic [N_LEDS-1:0] pat_q, pat_d;
   logic              dir_up_q, dir_up_d;

   // Idle level of the button is 1, so the synchroniser and debounced level reset high.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         db_level_q <= 1'b1;
         db_cnt_q   <= '0;
         press_q    <= 1'b0;
      end else begin
         sync1_q <= bus.button_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == db_level_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == D_LAST) begin
            db_level_q <= sync2_q;
            db_cnt_q   <= '0;
            press_q    <= ~sync2_q;
         end else begin
            db_cnt_q <= db_cnt_q + DW'(1);
         end
      end
   end

   assign tick = (timer_q == T_LAST);

   // A press restarts the step period and swallows any tick landing on the same edge.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         timer_q <= '0;
         step_q  <= 1'b0;
      end else begin
         step_q <= tick & ~press_q;
         if (press_q || tick) timer_q <= '0;
         else                 timer_q <= timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         mode_q   <= MODE_BLINK;
         pat_q    <= '0;
         dir_up_q <= 1'b1;
      end else begin
         mode_q   <= mode_d;
         pat_q    <= pat_d;
         dir_up_q <= dir_up_d;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      pat_d    = pat_q;
      dir_up_d = dir_up_q;
      if (press_q) begin
         mode_d   = mode_t'(mode_q + 2'd1);
         dir_up_d = 1'b1;
         case (mode_d)
            MODE_CHASE, MODE_BOUNCE: pat_d = PAT_ONE;
            default:                 pat_d = '0;
         endcase
      end else if (tick) begin
         case (mode_q)
            MODE_BLINK: pat_d = ~pat_q;
            MODE_CHASE: pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            MODE_BOUNCE: begin
               // Direction flips on the edge that lands the dot on an end bit.
               if (dir_up_q) begin
                  pat_d = pat_q << 1;
                  if (pat_q[N_LEDS-2]) dir_up_d = 1'b0;
               end else begin
                  pat_d = pat_q >> 1;
                  if (pat_q[1]) dir_up_d = 1'b1;
               end
            end
            MODE_COUNT: pat_d = pat_q + PAT_ONE;
            default:    pat_d = pat_q;
         endcase
      end
   end

   assign bus.led_o  = pat_q;
   assign bus.mode_o = mode_q;
   assign bus.step_o = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=4, STEP_CYCLES=4, DEBOUNCE_CYCLES=3.
module tb_led_pattern_gen;

   localparam int N = 4;
   localparam int S = 4;
   localparam int D = 3;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   led_pattern_gen_if #(.N_LEDS(N)) bus ();

   led_pattern_gen #(
      .N_LEDS(N),
      .STEP_CYCLES(S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk_i   (clk),
      .resetn_i(resetn),
      .bus     (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [N-1:0] exp_q[$];

   typedef struct {
      int           wait_cyc;
      logic         btn;
      logic [N-1:0] led;
      logic [1:0]   mode;
      logic         step;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input string name);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (bus.step_o !== 1'b1 && k < 12);
      check({name, "_step_seen"}, 32'(bus.step_o), 32'(1));
   endtask

   // Holds the button until the mode changes, checks the new mode and its initial pattern, then releases.
   task automatic press(input string name, input logic [1:0] exp_mode, input logic [N-1:0] exp_led);
      logic [1:0] old;
      int k;
      old = bus.mode_o;
      k = 0;
      bus.button_i = 1'b0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (bus.mode_o === old && k < 20);
      check({name, "_mode"}, 32'(bus.mode_o), 32'(exp_mode));
      check({name, "_led_init"}, 32'(bus.led_o), 32'(exp_led));
      bus.button_i = 1'b1;
   endtask

   // ---------------- test ----------------
   initial begin
      logic [N-1:0] exp;

      // cycle k = state after the k-th rising edge following reset release
      vecs[0]  = '{3, 1'b1, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1, 1'b1, 4'b1111, 2'd0, 1'b1};
      vecs[2]  = '{1, 1'b1, 4'b1111, 2'd0, 1'b0};
      vecs[3]  = '{3, 1'b1, 4'b0000, 2'd0, 1'b1};
      vecs[4]  = '{4, 1'b1, 4'b1111, 2'd0, 1'b1};
      vecs[5]  = '{4, 1'b1, 4'b0000, 2'd0, 1'b1};
      vecs[6]  = '{4, 1'b0, 4'b1111, 2'd0, 1'b1};
      vecs[7]  = '{1, 1'b0, 4'b1111, 2'd0, 1'b0};
      vecs[8]  = '{1, 1'b0, 4'b0001, 2'd1, 1'b0};
      vecs[9]  = '{4, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[10] = '{4, 1'b0, 4'b0100, 2'd1, 1'b1};
      vecs[11] = '{4, 1'b0, 4'b1000, 2'd1, 1'b1};
      vecs[12] = '{4, 1'b0, 4'b0001, 2'd1, 1'b1};
      vecs[13] = '{8, 1'b1, 4'b0100, 2'd1, 1'b1};

      bus.button_i = 1'b1;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_led", 32'(bus.led_o), 32'(0));
      check("rst_mode", 32'(bus.mode_o), 32'(0));
      check("rst_step", 32'(bus.step_o), 32'(0));
      resetn = 1'b1;

      // BLINK run, then a held press into CHASE and a release
      for (int i = 0; i < 14; i++) begin
         bus.button_i = vecs[i].btn;
         tick_n(vecs[i].wait_cyc);
         check($sformatf("vec%0d_led", i), 32'(bus.led_o), 32'(vecs[i].led));
         check($sformatf("vec%0d_mode", i), 32'(bus.mode_o), 32'(vecs[i].mode));
         check($sformatf("vec%0d_step", i), 32'(bus.step_o), 32'(vecs[i].step));
      end

      // BOUNCE sweep
      press("to_bounce", 2'd2, 4'b0001);
      exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         wait_step("bounce");
         check("bounce_led", 32'(bus.led_o), 32'(exp));
      end

      // COUNT through the all-ones wrap
      press("to_count", 2'd3, 4'b0000);
      for (int i = 1; i <= 16; i++) exp_q.push_back(4'(i));
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         wait_step("count");
         check("count_led", 32'(bus.led_o), 32'(exp));
      end

      // two-cycle glitches are rejected
      for (int r = 0; r < 4; r++) begin
         bus.button_i = 1'b0;
         tick_n(2);
         bus.button_i = 1'b1;
         tick_n(5);
         check($sformatf("glitch%0d_mode", r), 32'(bus.mode_o), 32'(3));
         check($sformatf("glitch%0d_dbcnt", r), 32'(dut.db_cnt_q), 32'(0));
      end

      // press accepted in the tick cycle: timer at 2 when the button falls
      wait_step("pre_coincide");
      tick_n(2);
      bus.button_i = 1'b0;
      tick_n(6);
      check("coincide_mode", 32'(bus.mode_o), 32'(0));
      check("coincide_led", 32'(bus.led_o), 32'(4'b0000));
      check("coincide_step", 32'(bus.step_o), 32'(0));
      bus.button_i = 1'b1;
      tick_n(3);
      check("coincide_step_gap", 32'(bus.step_o), 32'(0));
      tick_n(1);
      check("coincide_next_step", 32'(bus.step_o), 32'(1));
      check("coincide_next_led", 32'(bus.led_o), 32'(4'b1111));

      // reset mid-BOUNCE with a debounce in flight
      press("to_chase2", 2'd1, 4'b0001);
      tick_n(6);
      press("to_bounce2", 2'd2, 4'b0001);
      wait_step("bounce2a");
      check("bounce2a_led", 32'(bus.led_o), 32'(4'b0010));
      wait_step("bounce2b");
      check("bounce2b_led", 32'(bus.led_o), 32'(4'b0100));
      bus.button_i = 1'b0;
      tick_n(3);
      check("mid_debounce_cnt", 32'(dut.db_cnt_q), 32'(1));
      #3;
      resetn = 1'b0;
      #1;
      check("async_rst_led", 32'(bus.led_o), 32'(0));
      check("async_rst_mode", 32'(bus.mode_o), 32'(0));
      check("async_rst_step", 32'(bus.step_o), 32'(0));
      check("async_rst_dbcnt", 32'(dut.db_cnt_q), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      tick_n(4);
      check("post_rst_step", 32'(bus.step_o), 32'(1));
      check("post_rst_led", 32'(bus.led_o), 32'(4'b1111));
      check("post_rst_mode_k4", 32'(bus.mode_o), 32'(0));
      tick_n(1);
      check("post_rst_mode_k5", 32'(bus.mode_o), 32'(0));
      tick_n(1);
      check("post_rst_mode_k6", 32'(bus.mode_o), 32'(1));
      check("post_rst_led_k6", 32'(bus.led_o), 32'(4'b0001));
      bus.button_i = 1'b1;
      tick_n(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
